// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES controller-port responder.
package snes_pkg;

   typedef logic [11:0] snes_word_t;
   typedef logic [15:0] snes_report_t;

   typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} link_state_t;

   localparam snes_word_t  SNES_RELEASED    = 12'hFFF;
   localparam logic [3:0]  SNES_ID_BITS     = 4'hF;
   localparam int unsigned SNES_REPORT_BITS = 16;

   // ID nibble sits above the button bits and is shifted out last.
   function automatic snes_report_t snes_make_report(input snes_word_t word);
      return {SNES_ID_BITS, word};
   endfunction

endpackage

// File: rtl/snes_sync_edge.sv
// Multi-flop synchroniser for an asynchronous console line, followed by an
// edge-detect register producing single-cycle rise/fall strobes.
module snes_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/snes_link_controller.sv
// Controller-side SNES serial responder: holds recoder button words for a
// number of latch frames and shifts the 16-bit report out on snes_data.
module snes_link_controller
   import snes_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_FRAMES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [11:0] btn_word,
   input  logic       btn_valid,
   input  logic       snes_latch,
   input  logic       snes_clk,
   output logic       snes_data,
   output logic       busy,
   output logic       frame_done
);

   logic latch_rise, latch_fall, sclk_rise, sclk_fall_unused;

   snes_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b0)
   ) u_latch_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (snes_latch),
      .rise_o  (latch_rise),
      .fall_o  (latch_fall)
   );

   snes_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b1)
   ) u_clk_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (snes_clk),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall_unused)
   );

   link_state_t  state_q, state_d;
   snes_report_t shift_q, shift_d;
   logic [3:0]   bit_cnt_q, bit_cnt_d;
   logic         data_q, data_d;
   logic         frame_done_q, frame_done_d;
   snes_word_t   hold_word_q, hold_word_d;
   logic [7:0]   hold_cnt_q, hold_cnt_d;
   snes_word_t   load_word;

   // A strobe coinciding with a latch rise is reported in that very frame.
   always_comb begin
      hold_word_d = hold_word_q;
      hold_cnt_d  = hold_cnt_q;
      if (btn_valid) begin
         load_word = btn_word;
      end else if (hold_cnt_q != 8'd0) begin
         load_word = hold_word_q;
      end else begin
         load_word = SNES_RELEASED;
      end
      if (btn_valid && latch_rise) begin
         hold_word_d = btn_word;
         hold_cnt_d  = 8'(HOLD_FRAMES - 1);
      end else if (btn_valid) begin
         hold_word_d = btn_word;
         hold_cnt_d  = 8'(HOLD_FRAMES);
      end else if (latch_rise && (hold_cnt_q != 8'd0)) begin
         hold_cnt_d = hold_cnt_q - 8'd1;
      end
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      data_d       = data_q;
      frame_done_d = 1'b0;
      if (latch_rise) begin
         shift_d   = snes_make_report(load_word);
         bit_cnt_d = 4'd0;
         state_d   = LOADED;
         data_d    = load_word[0];
      end else begin
         unique case (state_q)
            IDLE: data_d = 1'b1;
            LOADED: begin
               data_d = shift_q[0];
               if (latch_fall) begin
                  state_d   = SHIFT;
                  bit_cnt_d = 4'd0;
               end
            end
            SHIFT: begin
               if (sclk_rise) begin
                  shift_d = {1'b0, shift_q[SNES_REPORT_BITS-1:1]};
                  if (bit_cnt_q == 4'(SNES_REPORT_BITS - 1)) begin
                     data_d       = 1'b0;
                     frame_done_d = 1'b1;
                     state_d      = DONE;
                  end else begin
                     data_d    = shift_q[1];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            DONE: data_d = 1'b0;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         shift_q      <= '1;
         bit_cnt_q    <= 4'd0;
         data_q       <= 1'b1;
         frame_done_q <= 1'b0;
         hold_word_q  <= SNES_RELEASED;
         hold_cnt_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         data_q       <= data_d;
         frame_done_q <= frame_done_d;
         hold_word_q  <= hold_word_d;
         hold_cnt_q   <= hold_cnt_d;
      end
   end

   assign snes_data  = data_q;
   assign busy       = (state_q == LOADED) || (state_q == SHIFT);
   assign frame_done = frame_done_q;

endmodule

// File: doc/snes_link_controller.md
Name: snes_link_controller

Overview:
Sequences the 12-bit active-low SNES button word onto the console's serial controller port. Holds each button word from the upstream button recoder for a programmable number of console poll frames. Synchronises the console's latch and clock lines into the system clock domain. Shifts the 16-bit report out on the data line, acting as the controller-side responder between the recoder and the SNES connector.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronisers on snes_latch and snes_clk (min 2)
HOLD_FRAMES, 3, number of console latch frames a captured button word is reported before reverting to all-released (1..255)

Ports:
clk  input  1  system clock (>= 8x the console serial clock rate)
reset  input  1  asynchronous, active-high reset
btn_word  input  12  active-low button word from recoder; bit0 = B, bit11 = R; 1 = released
btn_valid  input  1  one-cycle strobe; btn_word is captured on this cycle
snes_latch  input  1  console latch line, asynchronous, active-high pulse
snes_clk  input  1  console serial clock, asynchronous, idles high
snes_data  output  1  serial data to console, active-low per bit
busy  output  1  high while a report is being shifted (states LOADED, SHIFT)
frame_done  output  1  one-cycle pulse after the 16th bit is shifted

Behaviour:
- Reset values:
  - snes_data=1, busy=0, frame_done=0
  - hold_word=12'hFFF, hold_cnt=0, state=IDLE
  - synchroniser flops preset to 0 for the latch and 1 for the clock
- Synchronisers: SYNC_STAGES flops per line, then one edge-detect register. Edge detection therefore adds SYNC_STAGES+1 clk cycles of latency from the pin.
- Button hold:
  - On btn_valid: hold_word<=btn_word; hold_cnt<=HOLD_FRAMES.
  - On each detected latch rising edge with hold_cnt>0: hold_cnt decrements after loading.
  - When hold_cnt==0, the loaded word is 12'hFFF.
  - If btn_valid and a latch rise occur in the same cycle, the new btn_word is loaded and hold_cnt is set to HOLD_FRAMES-1.
- Report format, shift_reg[15:0]:
  - bits 11:0 = the loaded word
  - bits 15:12 = 4'b1111 (ID bits, released)
  - bit 0 is presented first.
- State machine:
  - IDLE: snes_data=1. A latch rise loads shift_reg and goes to LOADED. snes_data=shift_reg[0] from the next cycle.
  - LOADED: wait for latch fall, then go to SHIFT with bit_cnt=0. A new latch rise reloads shift_reg and stays in LOADED.
  - SHIFT:
    - Each detected snes_clk rising edge shifts right, filling with 0, and increments bit_cnt.
    - snes_data tracks shift_reg[0]. After 15 rising edges, bit 15 is on the line.
    - The 16th rising edge drives snes_data=0, pulses frame_done for one cycle and goes to DONE.
  - DONE: snes_data=0 until the next latch rise, which reloads and goes to LOADED.
- Latch rise in any state, including mid-SHIFT, aborts the current report: reload, bit_cnt=0, state LOADED, no frame_done pulse.
- snes_clk edges in IDLE, LOADED or DONE are ignored.
- Asynchronous reset mid-shift forces the reset values immediately; the console sees snes_data=1.
- snes_data is driven from a register (glitch-free).

Decomposition:
- Shared package snes_pkg:
  - typedef snes_word_t (logic[11:0]) and snes_report_t (logic[15:0])
  - enum link_state_t {IDLE, LOADED, SHIFT, DONE}
  - constants SNES_RELEASED=12'hFFF, SNES_ID_BITS=4'hF, SNES_REPORT_BITS=16
- Sub-module snes_sync_edge: parameterised synchroniser plus rise/fall detect. Instantiated twice, for latch and clock.

Test Plan:
- Reset asserted mid-SHIFT → snes_data=1, busy=0 immediately; the next latch begins a clean report of 16'hFFFF.
- btn_valid with btn_word=12'hFFE (B), then latch pulse and 16 clock pulses → bits read LSB first = 0,1,1,…,1; after the 16th, snes_data=0 and frame_done pulses once.
- HOLD_FRAMES=3, btn_word=12'hEFF, then 4 latch frames → frames 1–3 report 16'hFEFF, frame 4 reports 16'hFFFF.
- Latch rise after the 7th clock of a report → shift aborts, no frame_done, bit0 of the new report is on snes_data, busy stays 1.
- btn_valid (12'hFDF) in the same cycle as a latch rise → that frame reports 16'hFFDF; exactly HOLD_FRAMES-1 further frames report it.
- snes_clk toggling with no latch (IDLE) → snes_data stays 1 and no state change.
